icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter TAG_W, 24, tag width (address bits [31:8]); fixed, not overridden.
REQ-002 Parameter IDX_W, 3, set index width (address bits [7:5]; 8 sets); fixed.
REQ-003 Parameter LINE_WORDS, 8, 32-bit words per line (offset bits [4:2]); fixed.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 from_cpu_inst_req_valid  in  1 / from_cpu_inst_req_addr  in  32 / to_cpu_inst_req_ready  out  1: CPU fetch request handshake.
REQ-008 to_cpu_cache_rsp_valid  out  1 / to_cpu_cache_rsp_data  out  32 / from_cpu_cache_rsp_ready  in  1: CPU response handshake.
REQ-009 to_mem_rd_req_valid  out  1 / to_mem_rd_req_addr  out  32 / from_mem_rd_req_ready  in  1: line-refill request.
REQ-010 from_mem_rd_rsp_valid  in  1 / from_mem_rd_rsp_data  in  32 / from_mem_rd_rsp_last  in  1 / to_mem_rd_rsp_ready  out  1: refill beats.
REQ-011 tag_raddr, tag_waddr  out  3 / tag_wen  out  1 / tag_wdata  out  24 / tag_rdata  in  24 / tag_valid  in  1: tag array port (combinational read).
REQ-012 data_raddr, data_waddr  out  3 / data_wen  out  1 / data_wdata  out  256 / data_rdata  in  256: line data array port (combinational read).

Function
REQ-013 FSM states SHALL be IDLE, LOOKUP, MEM_REQ, RECV, REFILL, RESP; one-hot or binary free.
REQ-014 to_cpu_inst_req_ready SHALL be 1 only in IDLE; on valid&ready the address is latched and FSM goes to LOOKUP.
REQ-015 tag_raddr and data_raddr SHALL equal latched index bits [7:5] at all times.
REQ-016 LOOKUP: hit = tag_valid & (tag_rdata == latched[31:8]); hit -> RESP with data_rdata[32*off +: 32] registered as response word; miss -> MEM_REQ.
REQ-017 MEM_REQ: to_mem_rd_req_valid=1, addr = {latched[31:5], 5'b0}, held stable until from_mem_rd_req_ready; then RECV.
REQ-018 RECV: to_mem_rd_rsp_ready=1; each valid beat stores into line buffer word[cnt], cnt increments (3 bits); beat with last -> REFILL.
REQ-019 Beats after the 8th without last SHALL be accepted and discarded (cnt saturates at 7 after writing word 7).
REQ-020 REFILL: exactly one cycle with tag_wen=data_wen=1, tag_waddr=data_waddr=latched index, tag_wdata=latched tag, data_wdata = buffer with word0 at bits [31:0]; response word = buffer[off]; -> RESP.
REQ-021 RESP: to_cpu_cache_rsp_valid=1, data stable until from_cpu_cache_rsp_ready; then IDLE.
REQ-022 Hit latency: accept at cycle T, rsp_valid at T+2; no memory traffic on hit.
REQ-023 tag_wen/data_wen SHALL be 0 outside REFILL; valid-bit clearing is the tag array's responsibility.
REQ-024 Simultaneous req_valid in non-IDLE states SHALL be ignored (ready=0); one outstanding request only.

Reset
REQ-025 On rst=0 FSM SHALL enter IDLE immediately; all valid/wen/ready outputs 0 except to_cpu_inst_req_ready=1 after release; cnt, latched address, buffer cleared to 0.
REQ-026 Reset mid-refill SHALL abandon the line with no tag/data write; next request starts fresh.

Verification
REQ-027 Cold miss 0x0000_0104, tag_valid=0 -> mem req addr 0x0000_0100; beats 0xA0..0xA7, last on 8th -> one REFILL write tag 0x000001 index 0; rsp data 0xA1.
REQ-028 Then hit 0x0000_010C -> rsp 0xA3 at T+2, to_mem_rd_req_valid never asserted.
REQ-029 Conflict 0x0000_1104 (index 0, tag 0x000011) -> miss, refill beats 0xB0..0xB7, rsp 0xB1, tag_wdata 0x000011.
REQ-030 from_mem_rd_req_ready low 5 cycles -> req_valid held, addr 0x0000_0100 stable; from_cpu_cache_rsp_ready low 4 cycles -> rsp data held.
REQ-031 rst=0 asserted during 4th RECV beat -> outputs at reset values same cycle, no tag_wen pulse; subsequent miss completes normally.
REQ-032 Refill with 10 beats, last on 10th -> buffer holds first 8 beats only; single REFILL pulse.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 8 sets of 8-word lines.
// It looks up the external tag/data arrays, refills a line from memory on
// a miss and returns one 32-bit word to the CPU for each fetch.
module icache_ctrl #(
  parameter int TAG_W      = 24,
  parameter int IDX_W      = 3,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     from_cpu_inst_req_valid,
  input  logic [31:0]              from_cpu_inst_req_addr,
  output logic                     to_cpu_inst_req_ready,
  output logic                     to_cpu_cache_rsp_valid,
  output logic [31:0]              to_cpu_cache_rsp_data,
  input  logic                     from_cpu_cache_rsp_ready,
  output logic                     to_mem_rd_req_valid,
  output logic [31:0]              to_mem_rd_req_addr,
  input  logic                     from_mem_rd_req_ready,
  input  logic                     from_mem_rd_rsp_valid,
  input  logic [31:0]              from_mem_rd_rsp_data,
  input  logic                     from_mem_rd_rsp_last,
  output logic                     to_mem_rd_rsp_ready,
  output logic [IDX_W-1:0]         tag_raddr,
  output logic [IDX_W-1:0]         tag_waddr,
  output logic                     tag_wen,
  output logic [TAG_W-1:0]         tag_wdata,
  input  logic [TAG_W-1:0]         tag_rdata,
  input  logic                     tag_valid,
  output logic [IDX_W-1:0]         data_raddr,
  output logic [IDX_W-1:0]         data_waddr,
  output logic                     data_wen,
  output logic [32*LINE_WORDS-1:0] data_wdata,
  input  logic [32*LINE_WORDS-1:0] data_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_MEM_REQ = 3'd2,
    ST_RECV    = 3'd3,
    ST_REFILL  = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [31:2]             addr_r;
  logic [32*LINE_WORDS-1:0] line_buf_r;
  logic [2:0]              cnt_r;
  logic                    buf_full_r;
  logic [31:0]             rsp_data_r;
  logic                    ready_r;
  logic                    rsp_valid_r;
  logic                    mem_req_valid_r;
  logic                    mem_rsp_ready_r;
  logic                    wen_r;
  logic                    accept_s;
  logic                    hit_s;
  logic [TAG_W-1:0]        tag_s;
  logic [IDX_W-1:0]        idx_s;
  logic [2:0]              off_s;
  logic                    unused_addr_s;

  assign tag_s         = addr_r[31:8];
  assign idx_s         = addr_r[7:5];
  assign off_s         = addr_r[4:2];
  assign unused_addr_s = ^from_cpu_inst_req_addr[1:0];

  assign accept_s = from_cpu_inst_req_valid & ready_r;
  assign hit_s    = tag_valid & (tag_rdata == tag_s);

  assign to_cpu_inst_req_ready  = ready_r;
  assign to_cpu_cache_rsp_valid = rsp_valid_r;
  assign to_cpu_cache_rsp_data  = rsp_data_r;
  assign to_mem_rd_req_valid    = mem_req_valid_r;
  assign to_mem_rd_req_addr     = {addr_r[31:5], 5'b00000};
  assign to_mem_rd_rsp_ready    = mem_rsp_ready_r;
  assign tag_raddr              = idx_s;
  assign data_raddr             = idx_s;
  assign tag_waddr              = idx_s;
  assign data_waddr             = idx_s;
  assign tag_wen                = wen_r;
  assign data_wen               = wen_r;
  assign tag_wdata              = tag_s;
  assign data_wdata             = line_buf_r;

  // State register; reset abandons any refill in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode for the fetch/refill sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_LOOKUP;
        else          next_state_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s) next_state_s = ST_RESP;
        else       next_state_s = ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        if (from_mem_rd_req_ready) next_state_s = ST_RECV;
        else                       next_state_s = ST_MEM_REQ;
      end
      ST_RECV: begin
        if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) next_state_s = ST_REFILL;
        else                                               next_state_s = ST_RECV;
      end
      ST_REFILL: next_state_s = ST_RESP;
      ST_RESP: begin
        if (from_cpu_cache_rsp_ready) next_state_s = ST_IDLE;
        else                          next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Registered handshake/write-enable flags, decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r         <= 1'b0;
      rsp_valid_r     <= 1'b0;
      mem_req_valid_r <= 1'b0;
      mem_rsp_ready_r <= 1'b0;
      wen_r           <= 1'b0;
    end else begin
      ready_r         <= (next_state_s == ST_IDLE);
      rsp_valid_r     <= (next_state_s == ST_RESP);
      mem_req_valid_r <= (next_state_s == ST_MEM_REQ);
      mem_rsp_ready_r <= (next_state_s == ST_RECV);
      wen_r           <= (next_state_s == ST_REFILL);
    end
  end

  // Request address latch, refill line buffer with saturating beat counter,
  // and the response word (from the array on a hit, from the buffer on refill).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r     <= 30'd0;
      line_buf_r <= '0;
      cnt_r      <= 3'd0;
      buf_full_r <= 1'b0;
      rsp_data_r <= 32'd0;
    end else begin
      if (state_r == ST_IDLE && accept_s) begin
        addr_r     <= from_cpu_inst_req_addr[31:2];
        cnt_r      <= 3'd0;
        buf_full_r <= 1'b0;
      end
      if (state_r == ST_LOOKUP && hit_s) begin
        rsp_data_r <= data_rdata[{off_s, 5'b00000} +: 32];
      end
      // Beats past the eighth are still acknowledged but dropped.
      if (state_r == ST_RECV && from_mem_rd_rsp_valid && !buf_full_r) begin
        line_buf_r[{cnt_r, 5'b00000} +: 32] <= from_mem_rd_rsp_data;
        if (cnt_r == 3'd7) buf_full_r <= 1'b1;
        else               cnt_r      <= cnt_r + 3'd1;
      end
      if (state_r == ST_REFILL) begin
        rsp_data_r <= line_buf_r[{off_s, 5'b00000} +: 32];
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a behavioural tag/data array model.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         from_cpu_inst_req_valid;
  logic [31:0]  from_cpu_inst_req_addr;
  logic         to_cpu_inst_req_ready;
  logic         to_cpu_cache_rsp_valid;
  logic [31:0]  to_cpu_cache_rsp_data;
  logic         from_cpu_cache_rsp_ready;
  logic         to_mem_rd_req_valid;
  logic [31:0]  to_mem_rd_req_addr;
  logic         from_mem_rd_req_ready;
  logic         from_mem_rd_rsp_valid;
  logic [31:0]  from_mem_rd_rsp_data;
  logic         from_mem_rd_rsp_last;
  logic         to_mem_rd_rsp_ready;
  logic [2:0]   tag_raddr, tag_waddr, data_raddr, data_waddr;
  logic         tag_wen, data_wen;
  logic [23:0]  tag_wdata, tag_rdata;
  logic         tag_valid;
  logic [255:0] data_wdata, data_rdata;

  logic [23:0]  tag_mem [8];
  logic [255:0] data_mem [8];
  logic [7:0]   vld_r;
  logic         model_clr;
  int           wen_cnt = 0;
  int           memreq_cnt = 0;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk(clk), .rst(rst),
    .from_cpu_inst_req_valid(from_cpu_inst_req_valid),
    .from_cpu_inst_req_addr(from_cpu_inst_req_addr),
    .to_cpu_inst_req_ready(to_cpu_inst_req_ready),
    .to_cpu_cache_rsp_valid(to_cpu_cache_rsp_valid),
    .to_cpu_cache_rsp_data(to_cpu_cache_rsp_data),
    .from_cpu_cache_rsp_ready(from_cpu_cache_rsp_ready),
    .to_mem_rd_req_valid(to_mem_rd_req_valid),
    .to_mem_rd_req_addr(to_mem_rd_req_addr),
    .from_mem_rd_req_ready(from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid(from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data(from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last(from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready(to_mem_rd_rsp_ready),
    .tag_raddr(tag_raddr), .tag_waddr(tag_waddr), .tag_wen(tag_wen),
    .tag_wdata(tag_wdata), .tag_rdata(tag_rdata), .tag_valid(tag_valid),
    .data_raddr(data_raddr), .data_waddr(data_waddr), .data_wen(data_wen),
    .data_wdata(data_wdata), .data_rdata(data_rdata)
  );

  // Tag/data array model: combinational read, write on wen, valid bits kept
  // across controller resets.
  always @(posedge clk) begin
    if (model_clr) begin
      vld_r <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tag_mem[i]  <= 24'd0;
        data_mem[i] <= 256'd0;
      end
    end else begin
      if (tag_wen) begin
        tag_mem[tag_waddr] <= tag_wdata;
        vld_r[tag_waddr]   <= 1'b1;
      end
      if (data_wen) data_mem[data_waddr] <= data_wdata;
    end
  end

  // Activity counters for write pulses and memory request cycles.
  always @(posedge clk) begin
    if (tag_wen)             wen_cnt    <= wen_cnt + 1;
    if (to_mem_rd_req_valid) memreq_cnt <= memreq_cnt + 1;
  end

  assign tag_rdata  = tag_mem[tag_raddr];
  assign tag_valid  = vld_r[tag_raddr];
  assign data_rdata = data_mem[data_raddr];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_req(input logic [31:0] a);
    int n = 0;
    while (!to_cpu_inst_req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 256'(to_cpu_inst_req_ready), 256'(1'b1));
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = a;
    tick();
    from_cpu_inst_req_valid = 1'b0;
    chk("req_ready_busy", 256'(to_cpu_inst_req_ready), 256'(1'b0));
  endtask

  task automatic mem_grant(input logic [31:0] exp_addr, input int stall);
    int n = 0;
    while (!to_mem_rd_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk("mem_req_valid", 256'(to_mem_rd_req_valid), 256'(1'b1));
    chk("mem_req_addr", 256'(to_mem_rd_req_addr), 256'(exp_addr));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("mem_req_held", 256'(to_mem_rd_req_valid), 256'(1'b1));
      chk("mem_addr_held", 256'(to_mem_rd_req_addr), 256'(exp_addr));
      chk("busy_no_ready", 256'(to_cpu_inst_req_ready), 256'(1'b0));
    end
    from_mem_rd_req_ready = 1'b1;
    tick();
    from_mem_rd_req_ready = 1'b0;
    chk("recv_ready", 256'(to_mem_rd_rsp_ready), 256'(1'b1));
    chk("recv_req_drop", 256'(to_mem_rd_req_valid), 256'(1'b0));
  endtask

  task automatic mem_beats(input logic [31:0] base, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = base + 32'(i);
      from_mem_rd_rsp_last  = (i == nbeats - 1);
      tick();
    end
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_last  = 1'b0;
  endtask

  task automatic chk_refill(input logic [23:0] tag, input logic [2:0] idx, input logic [31:0] base);
    logic [255:0] line;
    for (int i = 0; i < 8; i++) line[32*i +: 32] = base + 32'(i);
    chk("refill_tag_wen", 256'(tag_wen), 256'(1'b1));
    chk("refill_data_wen", 256'(data_wen), 256'(1'b1));
    chk("refill_tag_waddr", 256'(tag_waddr), 256'(idx));
    chk("refill_data_waddr", 256'(data_waddr), 256'(idx));
    chk("refill_tag_wdata", 256'(tag_wdata), 256'(tag));
    chk("refill_line", data_wdata, line);
    tick();
    chk("refill_one_pulse", 256'(tag_wen), 256'(1'b0));
  endtask

  task automatic cpu_rsp(input logic [31:0] exp, input int stall);
    chk("rsp_valid", 256'(to_cpu_cache_rsp_valid), 256'(1'b1));
    chk("rsp_data", 256'(to_cpu_cache_rsp_data), 256'(exp));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("rsp_valid_held", 256'(to_cpu_cache_rsp_valid), 256'(1'b1));
      chk("rsp_data_held", 256'(to_cpu_cache_rsp_data), 256'(exp));
    end
    from_cpu_cache_rsp_ready = 1'b1;
    tick();
    from_cpu_cache_rsp_ready = 1'b0;
    chk("rsp_done", 256'(to_cpu_cache_rsp_valid), 256'(1'b0));
    chk("back_idle", 256'(to_cpu_inst_req_ready), 256'(1'b1));
  endtask

  // Watchdog against a hung handshake.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    int mr;
    int w;
    rst = 1'b0;
    model_clr = 1'b1;
    from_cpu_inst_req_valid  = 1'b0;
    from_cpu_inst_req_addr   = 32'd0;
    from_cpu_cache_rsp_ready = 1'b0;
    from_mem_rd_req_ready    = 1'b0;
    from_mem_rd_rsp_valid    = 1'b0;
    from_mem_rd_rsp_data     = 32'd0;
    from_mem_rd_rsp_last     = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 256'(to_cpu_inst_req_ready), 256'(1'b0));
    chk("rst_rsp_valid", 256'(to_cpu_cache_rsp_valid), 256'(1'b0));
    chk("rst_mem_req", 256'(to_mem_rd_req_valid), 256'(1'b0));
    chk("rst_mem_rsp_rdy", 256'(to_mem_rd_rsp_ready), 256'(1'b0));
    chk("rst_tag_wen", 256'(tag_wen), 256'(1'b0));
    chk("rst_raddr", 256'(tag_raddr), 256'(3'd0));
    chk("rst_rsp_data", 256'(to_cpu_cache_rsp_data), 256'(32'd0));
    model_clr = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 256'(to_cpu_inst_req_ready), 256'(1'b1));

    // Cold miss with request and response back-pressure.
    cpu_req(32'h0000_0104);
    mem_grant(32'h0000_0100, 5);
    mem_beats(32'h0000_00A0, 8);
    chk_refill(24'h000001, 3'd0, 32'h0000_00A0);
    cpu_rsp(32'h0000_00A1, 4);

    // Hit: response two cycles after acceptance, no memory traffic.
    mr = memreq_cnt;
    cpu_req(32'h0000_010C);
    chk("hit_t1_no_rsp", 256'(to_cpu_cache_rsp_valid), 256'(1'b0));
    tick();
    chk("hit_no_mem_req", 256'(to_mem_rd_req_valid), 256'(1'b0));
    cpu_rsp(32'h0000_00A3, 0);
    chk("hit_memreq_cnt", 256'(memreq_cnt), 256'(mr));

    // Conflict miss on set 0.
    cpu_req(32'h0000_1104);
    mem_grant(32'h0000_1100, 0);
    mem_beats(32'h0000_00B0, 8);
    chk_refill(24'h000011, 3'd0, 32'h0000_00B0);
    cpu_rsp(32'h0000_00B1, 0);

    // Reset during the fourth refill beat.
    w = wen_cnt;
    cpu_req(32'h0000_0244);
    mem_grant(32'h0000_0240, 0);
    mem_beats(32'h0000_00E0, 3);
    from_mem_rd_rsp_valid = 1'b1;
    from_mem_rd_rsp_data  = 32'h0000_00E3;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_ready", 256'(to_mem_rd_rsp_ready), 256'(1'b0));
    chk("mid_rst_tag_wen", 256'(tag_wen), 256'(1'b0));
    chk("mid_rst_req_ready", 256'(to_cpu_inst_req_ready), 256'(1'b0));
    chk("mid_rst_rsp_valid", 256'(to_cpu_cache_rsp_valid), 256'(1'b0));
    chk("mid_rst_raddr", 256'(tag_raddr), 256'(3'd0));
    from_mem_rd_rsp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ready_again", 256'(to_cpu_inst_req_ready), 256'(1'b1));
    chk("mid_rst_no_write", 256'(wen_cnt), 256'(w));
    cpu_req(32'h0000_0244);
    mem_grant(32'h0000_0240, 0);
    mem_beats(32'h0000_00C0, 8);
    chk_refill(24'h000002, 3'd2, 32'h0000_00C0);
    cpu_rsp(32'h0000_00C1, 0);

    // Ten beats: only the first eight land in the line, one write pulse.
    w = wen_cnt;
    cpu_req(32'h0000_037C);
    mem_grant(32'h0000_0360, 0);
    mem_beats(32'h0000_00D0, 10);
    chk_refill(24'h000003, 3'd3, 32'h0000_00D0);
    cpu_rsp(32'h0000_00D7, 0);
    chk("ten_beat_one_write", 256'(wen_cnt), 256'(w + 1));
    cpu_req(32'h0000_0374);
    tick();
    cpu_rsp(32'h0000_00D5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
